fram_ctrl: RTL and testbench
============================

FRAM_CTRL -- requirements
Module: fram_ctrl

Interface
REQ-001 Parameter START, 17 bits, default 17'h08000: first byte address of the FRAM window.
REQ-002 Parameter DEPTH, 17 bits, default 17'h08000: window size in bytes.
REQ-003 Parameter NWAITS, integer 0..7, default 1: wait states inserted per FRAM access.
REQ-004 MCLK  in  1  system clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 cpuREQ  in  1  CPU access request, valid with cpuMAB, cpuMW and cpuBW.
REQ-007 cpuMAB  in  16  CPU address.
REQ-008 cpuMDBwrite  in  16  CPU write data.
REQ-009 cpuMW, cpuBW  in  1 each  CPU write strobe and byte/word select (1 = byte).
REQ-010 cpuMDBread  out  16  read data to CPU.
REQ-011 cpuWAIT  out  1  stall; while it is high the CPU holds its bus stable.
REQ-012 memMAB, memMDBwrite  out  16 each  memory-side address and data.
REQ-013 memMW, memBW  out  1 each  memory-side write strobe and byte select.
REQ-014 memMDBread  in  16  shared memory read bus, Hi-Z when no region decodes.

Function
REQ-015 hit = cpuREQ and START <= cpuMAB < START+DEPTH, compared at 17-bit width so no wrap occurs.
REQ-016 FSM states: IDLE, WAIT, ACCESS.
REQ-017 IDLE, no hit (or NWAITS=0): memory outputs follow the cpu inputs combinationally, cpuMDBread = memMDBread, cpuWAIT=0, zero latency.
REQ-018 IDLE, hit, NWAITS>0: cpuWAIT=1 and memMW=0 in the same cycle; latch MAB, MDBwrite, MW and BW; next state is WAIT if NWAITS>1, else ACCESS.
REQ-019 WAIT: cpuWAIT=1, memMW=0, memory outputs driven from the latched values; a down-counter loaded with NWAITS-2 decrements each cycle; move to ACCESS at 0.
REQ-020 ACCESS: cpuWAIT=0, memory outputs = latched values (memMW = latched MW), cpuMDBread = memMDBread; next state IDLE.
REQ-021 Cycle budget: request in cycle 0, cpuWAIT high in cycles 0..NWAITS-1, data and write commit in cycle NWAITS (write on the closing posedge).
REQ-022 An access is committed once latched; cpuREQ deasserting or cpu inputs changing during WAIT/ACCESS has no effect.
REQ-023 A new hit is accepted only in IDLE, so back-to-back hits cost NWAITS+1 cycles each.
REQ-024 Byte/word semantics pass through unchanged; the controller never modifies data or aligns addresses.

Reset
REQ-025 reset forces, asynchronously: state IDLE, counter 0, latches 0, cpuWAIT=0, prefetch buffer invalid.
REQ-026 reset during WAIT/ACCESS aborts the access; the pending write never reaches memory (memMW=0).
REQ-027 After reset release, the memory outputs follow the cpu inputs per REQ-017.

Configuration
REQ-028 Macro FRAM_PREFETCH_EN compiles in a one-word read buffer holding a valid bit, a 15-bit word tag and 16 data bits.
REQ-029 With the macro, each ACCESS read loads tag = latched MAB[15:1] and data = memMDBread, and sets valid.
REQ-030 With the macro, a read hit (MW=0) whose MAB[15:1] matches a valid tag completes in IDLE with zero wait. Data is the word, or {8'h00, byte selected by MAB[0]} when BW=1.
REQ-031 With the macro, any in-range write (committed in ACCESS) clears valid.
REQ-032 Without the macro, no buffer exists and every hit with NWAITS>0 follows REQ-018..021.

Verification
REQ-033 NWAITS=1, read 8000h (holds 1234h) -> cpuWAIT high 1 cycle, cpuMDBread=1234h in the next cycle.
REQ-034 NWAITS=3, word write 5A5Ah to 9002h -> memMW=0 for 3 cycles, memMW=1 in the 4th, readback 5A5Ah.
REQ-035 Read 2000h (outside window) -> cpuWAIT never asserts, cpuMDBread = memMDBread in the same cycle.
REQ-036 NWAITS=2, write to 8010h, reset asserted in the WAIT cycle -> memMW never 1, cpuWAIT=0 immediately, 8010h unchanged.
REQ-037 FRAM_PREFETCH_EN, NWAITS=2: read 8004h (ABCDh) -> 2 waits; byte read 8005h -> 0 waits, returns 00ABh; write 8004h, reread -> 2 waits.

Source files
------------

// File: rtl/fram_ctrl.sv
// FRAM wait-state controller: stalls the CPU for NWAITS cycles on accesses inside the window.
// Optional one-word read buffer compiled in with `define FRAM_PREFETCH_EN.
`timescale 1ns/1ps
module fram_ctrl #(
  parameter logic [16:0] START  = 17'h08000,
  parameter logic [16:0] DEPTH  = 17'h08000,
  parameter int          NWAITS = 1
) (
  input  logic        MCLK,
  input  logic        reset,
  input  logic        cpuREQ,
  input  logic [15:0] cpuMAB,
  input  logic [15:0] cpuMDBwrite,
  input  logic        cpuMW,
  input  logic        cpuBW,
  output logic [15:0] cpuMDBread,
  output logic        cpuWAIT,
  output logic [15:0] memMAB,
  output logic [15:0] memMDBwrite,
  output logic        memMW,
  output logic        memBW,
  input  logic [15:0] memMDBread
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  localparam logic [16:0] LIMIT    = START + DEPTH;
  localparam logic [2:0]  CNT_INIT = (NWAITS >= 2) ? 3'(NWAITS - 2) : 3'd0;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [15:0] mab_reg, mdb_reg;
  logic        mw_reg, bw_reg;
  logic        hit, accept;
  logic        pf_hit;
  logic [15:0] pf_rdata;

  // 17-bit compare so a window ending at 10000h does not wrap
  assign hit = cpuREQ && ({1'b0, cpuMAB} >= START) && ({1'b0, cpuMAB} < LIMIT);

`ifdef FRAM_PREFETCH_EN
  logic        pf_valid_reg;
  logic [14:0] pf_tag_reg;
  logic [15:0] pf_data_reg;

  assign pf_hit   = hit && !cpuMW && pf_valid_reg && (cpuMAB[15:1] == pf_tag_reg);
  assign pf_rdata = cpuBW ? {8'h00, (cpuMAB[0] ? pf_data_reg[15:8] : pf_data_reg[7:0])}
                          : pf_data_reg;

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      pf_valid_reg <= 1'b0;
      pf_tag_reg   <= 15'd0;
      pf_data_reg  <= 16'h0000;
    end else if (state_reg == S_ACCESS) begin
      if (mw_reg) begin
        pf_valid_reg <= 1'b0;
      end else begin
        pf_valid_reg <= 1'b1;
        pf_tag_reg   <= mab_reg[15:1];
        pf_data_reg  <= memMDBread;
      end
    end
  end
`else
  assign pf_hit   = 1'b0;
  assign pf_rdata = 16'h0000;
`endif

  assign accept = hit && (NWAITS > 0) && !pf_hit;

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Once latched the access is committed; later CPU bus changes are ignored
  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      mab_reg <= 16'h0000;
      mdb_reg <= 16'h0000;
      mw_reg  <= 1'b0;
      bw_reg  <= 1'b0;
    end else if ((state_reg == S_IDLE) && accept) begin
      mab_reg <= cpuMAB;
      mdb_reg <= cpuMDBwrite;
      mw_reg  <= cpuMW;
      bw_reg  <= cpuBW;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = (NWAITS > 1) ? S_WAIT : S_ACCESS;
          cnt_next   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_reg == 3'd0) state_next = S_ACCESS;
        else                 cnt_next   = cnt_reg - 3'd1;
      end
      S_ACCESS: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    memMAB      = cpuMAB;
    memMDBwrite = cpuMDBwrite;
    memMW       = cpuMW;
    memBW       = cpuBW;
    cpuMDBread  = memMDBread;
    cpuWAIT     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          cpuWAIT = 1'b1;
          memMW   = 1'b0;
        end else if (pf_hit) begin
          cpuMDBread = pf_rdata;
        end
      end
      S_WAIT: begin
        memMAB      = mab_reg;
        memMDBwrite = mdb_reg;
        memMW       = 1'b0;
        memBW       = bw_reg;
        cpuWAIT     = 1'b1;
      end
      S_ACCESS: begin
        memMAB      = mab_reg;
        memMDBwrite = mdb_reg;
        memMW       = mw_reg;
        memBW       = bw_reg;
      end
      default: cpuWAIT = 1'b0;
    endcase
    // An in-flight write must never reach memory while reset is held
    if (reset) begin
      cpuWAIT = 1'b0;
      memMW   = 1'b0;
    end
  end

endmodule

// File: tb/tb_fram_ctrl.sv
// Directed bench for fram_ctrl: three instances with NWAITS = 1, 2, 3, each with its own memory.
`timescale 1ns/1ps
module tb_fram_ctrl;

  logic        MCLK;
  logic        reset;
  logic [15:0] cpu_mab;
  logic [15:0] cpu_wdata;
  logic        cpu_bw;
  logic        cpu_req   [3];
  logic        cpu_mw    [3];
  logic [15:0] rd_a      [3];
  logic        wait_a    [3];
  logic [15:0] mem_mab_a [3];
  logic [15:0] mem_wd_a  [3];
  logic        mem_mw_a  [3];
  logic        mem_bw_a  [3];

  int checks;
  int failures;

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    logic [15:0] mem [0:32767];
    logic [15:0] mem_rd;

    assign mem_rd = mem[mem_mab_a[gi][15:1]];

    fram_ctrl #(
      .START (17'h08000),
      .DEPTH (17'h08000),
      .NWAITS(gi + 1)
    ) u_dut (
      .MCLK       (MCLK),
      .reset      (reset),
      .cpuREQ     (cpu_req[gi]),
      .cpuMAB     (cpu_mab),
      .cpuMDBwrite(cpu_wdata),
      .cpuMW      (cpu_mw[gi]),
      .cpuBW      (cpu_bw),
      .cpuMDBread (rd_a[gi]),
      .cpuWAIT    (wait_a[gi]),
      .memMAB     (mem_mab_a[gi]),
      .memMDBwrite(mem_wd_a[gi]),
      .memMW      (mem_mw_a[gi]),
      .memBW      (mem_bw_a[gi]),
      .memMDBread (mem_rd)
    );

    always @(posedge MCLK) begin
      if (mem_mw_a[gi]) begin
        if (!mem_bw_a[gi])         mem[mem_mab_a[gi][15:1]]       = mem_wd_a[gi];
        else if (mem_mab_a[gi][0]) mem[mem_mab_a[gi][15:1]][15:8] = mem_wd_a[gi][15:8];
        else                       mem[mem_mab_a[gi][15:1]][7:0]  = mem_wd_a[gi][7:0];
      end
    end

    initial begin
      for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
      mem[15'h4000] = 16'h1234;  // 8000h
      mem[15'h4002] = 16'hABCD;  // 8004h
      mem[15'h4008] = 16'h1111;  // 8010h
      mem[15'h1000] = 16'h0BEE;  // 2000h
      mem[15'h3FFF] = 16'h7E7E;  // 7FFEh
      mem[15'h7FFF] = 16'hF00D;  // FFFEh
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One CPU transaction; holds the bus until cpuWAIT drops, then samples the result
  task automatic do_access(input int idx, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic mw, input logic bw, output int waits,
                           output logic [15:0] rdata, output logic early_mw, output logic final_mw);
    @(negedge MCLK);
    cpu_mab     = addr;
    cpu_wdata   = wdata;
    cpu_bw      = bw;
    cpu_mw[idx] = mw;
    cpu_req[idx] = 1'b1;
    waits    = 0;
    early_mw = 1'b0;
    #1;
    while (wait_a[idx] && waits < 16) begin
      waits++;
      if (mem_mw_a[idx]) early_mw = 1'b1;
      @(negedge MCLK);
      #1;
    end
    check_value("wait_released", 32'(wait_a[idx]), 32'd0);
    rdata    = rd_a[idx];
    final_mw = mem_mw_a[idx];
    $display("txn dut%0d addr=%h wdata=%h mw=%b bw=%b waits=%0d rdata=%h memMW=%b",
             idx, addr, wdata, mw, bw, waits, rdata, final_mw);
    @(negedge MCLK);
    cpu_req[idx] = 1'b0;
    cpu_mw[idx]  = 1'b0;
  endtask

  int          w;
  logic [15:0] d;
  logic        em, fm;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    cpu_mab  = 16'h8000;
    cpu_wdata = 16'hDEAD;
    cpu_bw   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_req[i] = 1'b0;
      cpu_mw[i]  = 1'b0;
    end
    cpu_req[0] = 1'b1;
    cpu_mw[0]  = 1'b1;
    repeat (2) @(posedge MCLK);
    @(negedge MCLK);
    #1;
    check_value("reset_wait", 32'(wait_a[0]), 32'd0);
    check_value("reset_memMW", 32'(mem_mw_a[0]), 32'd0);
    check_value("reset_memMAB", 32'(mem_mab_a[0]), 32'h8000);
    cpu_req[0] = 1'b0;
    cpu_mw[0]  = 1'b0;
    @(negedge MCLK);
    reset = 1'b0;

    // Outside the window: zero latency pass-through
    do_access(0, 16'h2000, 16'h0000, 1'b0, 1'b0, w, d, em, fm);
    check_value("out_waits", 32'(w), 32'd0);
    check_value("out_data", 32'(d), 32'h0BEE);
    do_access(0, 16'h7FFE, 16'h0000, 1'b0, 1'b0, w, d, em, fm);
    check_value("below_start_waits", 32'(w), 32'd0);
    check_value("below_start_data", 32'(d), 32'h7E7E);
    do_access(0, 16'hFFFE, 16'h0000, 1'b0, 1'b0, w, d, em, fm);
    check_value("top_waits", 32'(w), 32'd1);
    check_value("top_data", 32'(d), 32'hF00D);

    // NWAITS=1 read
    do_access(0, 16'h8000, 16'h0000, 1'b0, 1'b0, w, d, em, fm);
    check_value("n1_read_waits", 32'(w), 32'd1);
    check_value("n1_read_data", 32'(d), 32'h1234);

    // NWAITS=1 byte write of the high byte, then word readback
    do_access(0, 16'h8001, 16'h7777, 1'b1, 1'b1, w, d, em, fm);
    check_value("n1_bwrite_waits", 32'(w), 32'd1);
    check_value("n1_bwrite_memMW", 32'(fm), 32'd1);
    do_access(0, 16'h8000, 16'h0000, 1'b0, 1'b0, w, d, em, fm);
    check_value("n1_bwrite_readback", 32'(d), 32'h7734);

    // NWAITS=3 word write and readback
    do_access(2, 16'h9002, 16'h5A5A, 1'b1, 1'b0, w, d, em, fm);
    check_value("n3_write_waits", 32'(w), 32'd3);
    check_value("n3_write_early_memMW", 32'(em), 32'd0);
    check_value("n3_write_commit_memMW", 32'(fm), 32'd1);
    do_access(2, 16'h9002, 16'h0000, 1'b0, 1'b0, w, d, em, fm);
    check_value("n3_readback_waits", 32'(w), 32'd3);
    check_value("n3_readback_data", 32'(d), 32'h5A5A);

    // NWAITS=2 write aborted by reset while in WAIT
    @(negedge MCLK);
    cpu_mab   = 16'h8010;
    cpu_wdata = 16'hFFFF;
    cpu_bw    = 1'b0;
    cpu_mw[1] = 1'b1;
    cpu_req[1] = 1'b1;
    #1;
    check_value("abort_idle_wait", 32'(wait_a[1]), 32'd1);
    check_value("abort_idle_memMW", 32'(mem_mw_a[1]), 32'd0);
    @(negedge MCLK);
    #1;
    check_value("abort_inwait_wait", 32'(wait_a[1]), 32'd1);
    reset = 1'b1;
    #1;
    check_value("abort_rst_wait", 32'(wait_a[1]), 32'd0);
    check_value("abort_rst_memMW", 32'(mem_mw_a[1]), 32'd0);
    cpu_req[1] = 1'b0;
    cpu_mw[1]  = 1'b0;
    @(negedge MCLK);
    reset = 1'b0;
    $display("txn dut1 addr=8010 write aborted by reset");
    do_access(1, 16'h8010, 16'h0000, 1'b0, 1'b0, w, d, em, fm);
    check_value("abort_readback_waits", 32'(w), 32'd2);
    check_value("abort_readback_data", 32'(d), 32'h1111);

    // Read buffer sequence on NWAITS=2
    do_access(1, 16'h8004, 16'h0000, 1'b0, 1'b0, w, d, em, fm);
    check_value("pf_first_waits", 32'(w), 32'd2);
    check_value("pf_first_data", 32'(d), 32'hABCD);
    do_access(1, 16'h8005, 16'h0000, 1'b0, 1'b1, w, d, em, fm);
`ifdef FRAM_PREFETCH_EN
    check_value("pf_byte_waits", 32'(w), 32'd0);
    check_value("pf_byte_data", 32'(d), 32'h00AB);
`else
    check_value("pf_byte_waits", 32'(w), 32'd2);
    check_value("pf_byte_data", 32'(d), 32'hABCD);
`endif
    do_access(1, 16'h8004, 16'h0000, 1'b0, 1'b0, w, d, em, fm);
`ifdef FRAM_PREFETCH_EN
    check_value("pf_word_waits", 32'(w), 32'd0);
`else
    check_value("pf_word_waits", 32'(w), 32'd2);
`endif
    check_value("pf_word_data", 32'(d), 32'hABCD);
    do_access(1, 16'h8004, 16'h1357, 1'b1, 1'b0, w, d, em, fm);
    check_value("pf_write_waits", 32'(w), 32'd2);
    check_value("pf_write_memMW", 32'(fm), 32'd1);
    do_access(1, 16'h8004, 16'h0000, 1'b0, 1'b0, w, d, em, fm);
    check_value("pf_reread_waits", 32'(w), 32'd2);
    check_value("pf_reread_data", 32'(d), 32'h1357);

    repeat (2) @(negedge MCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
